// File: rtl/arbiter_rr_packet.sv
// Packet-aware round-robin arbiter: one requester owns the output from grant until its
// last beat transfers, feeding a single registered output stage with full throughput.
module arbiter_rr_packet #(
    parameter int N = 8,
    parameter int DWIDTH = 32,
    localparam int IW = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          in_valid,
    input  logic [N*DWIDTH-1:0]   in_data,
    input  logic [N-1:0]          in_last,
    output logic [N-1:0]          in_ready,
    output logic                  out_valid,
    output logic [DWIDTH-1:0]     out_data,
    output logic                  out_last,
    output logic [IW-1:0]         out_id,
    input  logic                  out_ready
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    logic [0:0]        r_state;
    logic [IW-1:0]     r_owner;
    logic [IW-1:0]     r_lastOwner;
    logic              r_outValid;
    logic [DWIDTH-1:0] r_outData;
    logic              r_outLast;
    logic [IW-1:0]     r_outId;

    logic              w_maskHit;
    logic [IW-1:0]     w_maskIdx;
    logic [IW-1:0]     w_anyIdx;
    logic [IW-1:0]     w_winner;
    logic              w_ownerReady;
    logic              w_xfer;
    logic [DWIDTH-1:0] w_ownerData;

    // Scanning downward leaves the lowest matching index in each candidate.
    always_comb begin
        w_maskHit = 1'b0;
        w_maskIdx = '0;
        w_anyIdx  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                w_anyIdx = IW'(i);
                if (IW'(i) > r_lastOwner) begin
                    w_maskHit = 1'b1;
                    w_maskIdx = IW'(i);
                end
            end
        end
    end

    assign w_winner     = w_maskHit ? w_maskIdx : w_anyIdx;
    assign w_ownerReady = !r_outValid || out_ready;
    assign w_xfer       = (r_state == S_LOCKED) && in_valid[r_owner] && w_ownerReady;
    assign w_ownerData  = in_data[r_owner*DWIDTH +: DWIDTH];

    always_comb begin
        in_ready = '0;
        if (r_state == S_LOCKED) begin
            in_ready[r_owner] = w_ownerReady;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_lastOwner <= IW'(N - 1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|in_valid) begin
                        r_state <= S_LOCKED;
                        r_owner <= w_winner;
                    end
                end
                default: begin
                    // Lock is released only by a transferred last beat, never by a valid gap.
                    if (w_xfer && in_last[r_owner]) begin
                        r_state     <= S_IDLE;
                        r_lastOwner <= r_owner;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outLast  <= 1'b0;
            r_outId    <= '0;
        end else if (w_xfer) begin
            r_outValid <= 1'b1;
            r_outData  <= w_ownerData;
            r_outLast  <= in_last[r_owner];
            r_outId    <= r_owner;
        end else if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_last  = r_outLast;
    assign out_id    = r_outId;

endmodule

// File: tb/tb_arbiter_rr_packet.sv
// Bench for arbiter_rr_packet: per-requester beat sources, an ordered scoreboard of
// expected output beats, a table of arbitration patterns and hand-written corner sequences.
module tb_arbiter_rr_packet;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int MAXB = 8;

    typedef struct {
        logic [2:0]  id;
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [7:0] valid;
        int         e0;
        int         e1;
        int         e2;
    } vec_t;

    logic            clk;
    logic            rst;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_last;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic [2:0]      out_id;
    logic            out_ready;

    logic [31:0] bData [N][MAXB];
    logic        bLast [N][MAXB];
    int          bCnt [N];
    int          bPtr [N];
    logic [N-1:0] pause;

    beat_t sbQ[$];
    vec_t  vecs[8];

    logic         sOutValid;
    logic [31:0]  sOutData;
    logic [2:0]   sOutId;
    logic         sOutLast;
    logic [N-1:0] sInReady;

    int nChecks;
    int nFail;

    arbiter_rr_packet #(.N(N), .DWIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_id(out_id),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pktData(int r, int k, int tag);
        return {8'(r), 8'(k), 16'(tag)};
    endfunction

    task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic reportTimeout(string name);
        nChecks++;
        nFail++;
        $display("[TB] FAIL %s: timed out, %0d expected beats outstanding", name, sbQ.size());
    endtask

    // Drives one cycle of source state, samples at the falling edge, retires accepted beats.
    task automatic applyStimulus();
        logic [N-1:0] xfer;
        for (int i = 0; i < N; i++) begin
            if (bPtr[i] < bCnt[i]) begin
                in_valid[i]         = !pause[i];
                in_data[i*DW +: DW] = bData[i][bPtr[i]];
                in_last[i]          = bLast[i][bPtr[i]];
            end else begin
                in_valid[i]         = 1'b0;
                in_data[i*DW +: DW] = '0;
                in_last[i]          = 1'b0;
            end
        end
        @(negedge clk);
        sOutValid = out_valid;
        sOutData  = out_data;
        sOutId    = out_id;
        sOutLast  = out_last;
        sInReady  = in_ready;
        xfer      = in_valid & in_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (xfer[i]) bPtr[i]++;
        end
    endtask

    task automatic applyReset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            bCnt[i] = 0;
            bPtr[i] = 0;
        end
        pause = '0;
        sbQ.delete();
        out_ready = 1'b1;
        applyStimulus();
        rst = 1'b0;
    endtask

    task automatic loadBeat(int r, logic [31:0] d, logic l);
        bData[r][bCnt[r]] = d;
        bLast[r][bCnt[r]] = l;
        bCnt[r]++;
    endtask

    task automatic expectBeat(int id, logic [31:0] d, logic l);
        beat_t b;
        b.id   = 3'(id);
        b.data = d;
        b.last = l;
        sbQ.push_back(b);
    endtask

    task automatic loadPacket(int r, int beats, int tag);
        for (int k = 0; k < beats; k++) begin
            loadBeat(r, pktData(r, k, tag), k == beats - 1);
        end
    endtask

    task automatic expectPacket(int r, int beats, int tag);
        for (int k = 0; k < beats; k++) begin
            expectBeat(r, pktData(r, k, tag), k == beats - 1);
        end
    endtask

    task automatic drain(string name, int budget);
        int n = 0;
        while (sbQ.size() != 0 && n < budget) begin
            applyStimulus();
            n++;
        end
        if (sbQ.size() != 0) reportTimeout(name);
    endtask

    task automatic waitOutValid(string name, int budget);
        int n = 0;
        do begin
            applyStimulus();
            n++;
        end while (!sOutValid && n < budget);
        if (!sOutValid) reportTimeout(name);
    endtask

    // Scoreboard: every accepted output beat must match the next expected one in order.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready) begin
            if (sbQ.size() == 0) begin
                nChecks++;
                nFail++;
                $display("[TB] FAIL unexpected beat: got id %0d data %0h, expected none", out_id, out_data);
            end else begin
                beat_t e;
                e = sbQ.pop_front();
                checkOutput("beat id/last/data", {out_id, out_last, out_data}, {e.id, e.last, e.data});
            end
        end
    end

    initial begin
        int firstHigh;
        int svc [N];
        rst = 1'b1;
        out_ready = 1'b1;
        in_valid = '0;
        in_data = '0;
        in_last = '0;
        pause = '0;
        nChecks = 0;
        nFail = 0;
        for (int i = 0; i < N; i++) begin
            bCnt[i] = 0;
            bPtr[i] = 0;
        end

        vecs[0] = '{8'b0000_0101, 0, 2, 0};
        vecs[1] = '{8'b1000_0001, 0, 7, 0};
        vecs[2] = '{8'b1000_0000, 7, 7, 7};
        vecs[3] = '{8'b1111_1111, 0, 1, 2};
        vecs[4] = '{8'b0110_0000, 5, 6, 5};
        vecs[5] = '{8'b0000_0010, 1, 1, 1};
        vecs[6] = '{8'b0101_0000, 4, 6, 4};
        vecs[7] = '{8'b0000_1100, 2, 3, 2};

        // Reset state and first-grant latency
        applyReset();
        applyReset();
        applyStimulus();
        checkOutput("reset out_valid", sOutValid, 0);
        checkOutput("reset out_data/id/last", {sOutData, sOutId, sOutLast}, 0);
        checkOutput("reset in_ready", sInReady, 0);
        loadPacket(0, 1, 16'h0A00);
        loadPacket(2, 1, 16'h0A00);
        expectPacket(0, 1, 16'h0A00);
        expectPacket(2, 1, 16'h0A00);
        firstHigh = -1;
        for (int c = 0; c < 5; c++) begin
            applyStimulus();
            if (c == 0) checkOutput("idle in_ready", sInReady, 0);
            if (sOutValid && firstHigh < 0) firstHigh = c;
        end
        checkOutput("first beat latency", 64'(firstHigh), 2);
        drain("latency drain", 30);

        // Arbitration table, three single-beat grants per pattern
        for (int v = 0; v < 8; v++) begin
            int ex [3];
            applyReset();
            for (int r = 0; r < N; r++) begin
                svc[r] = 0;
                if (vecs[v].valid[r]) begin
                    for (int k = 0; k < 3; k++) loadBeat(r, pktData(r, k, v), 1'b1);
                end
            end
            ex[0] = vecs[v].e0;
            ex[1] = vecs[v].e1;
            ex[2] = vecs[v].e2;
            for (int j = 0; j < 3; j++) begin
                expectBeat(ex[j], pktData(ex[j], svc[ex[j]], v), 1'b1);
                svc[ex[j]]++;
            end
            drain("table vector", 40);
        end

        // All requesters busy: full rotation then wrap to 0
        applyReset();
        for (int r = 0; r < N; r++) begin
            loadPacket(r, 1, 16'h0B00);
            loadPacket(r, 1, 16'h0B01);
        end
        for (int r = 0; r < N; r++) expectPacket(r, 1, 16'h0B00);
        expectPacket(0, 1, 16'h0B01);
        drain("rotation", 60);

        // 4-beat packet from 3 must stay contiguous while 1 waits
        applyReset();
        loadPacket(3, 4, 16'h0C00);
        applyStimulus();
        loadPacket(1, 1, 16'h0C01);
        expectPacket(3, 4, 16'h0C00);
        expectPacket(1, 1, 16'h0C01);
        waitOutValid("packet start", 10);
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            checkOutput("contiguous beat", {sOutValid, sOutId}, {1'b1, 3'd3});
        end
        drain("packet drain", 20);

        // Downstream stall of 5 cycles mid-packet
        applyReset();
        loadPacket(5, 6, 16'h0D00);
        expectPacket(5, 6, 16'h0D00);
        waitOutValid("stall start", 10);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus();
            checkOutput("stall data held", {sOutValid, sOutData}, {1'b1, pktData(5, 1, 16'h0D00)});
            if (k >= 1) checkOutput("stall in_ready", sInReady, 0);
        end
        out_ready = 1'b1;
        drain("stall drain", 30);

        // Owner gap of 3 cycles must not release the lock
        applyReset();
        loadPacket(6, 4, 16'h0E00);
        applyStimulus();
        loadPacket(0, 1, 16'h0E01);
        expectPacket(6, 4, 16'h0E00);
        expectPacket(0, 1, 16'h0E01);
        waitOutValid("gap start", 10);
        pause[6] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            checkOutput("gap in_ready[0]", sInReady[0], 0);
        end
        pause[6] = 1'b0;
        drain("gap drain", 30);

        // Reset mid-packet aborts and restarts priority at index 0
        applyReset();
        loadPacket(4, 1, 16'h0F00);
        expectPacket(4, 1, 16'h0F00);
        drain("prime owner", 20);
        loadPacket(2, 4, 16'h0F01);
        expectBeat(2, pktData(2, 0, 16'h0F01), 1'b0);
        waitOutValid("abort start", 10);
        applyReset();
        applyStimulus();
        checkOutput("post-reset out_valid", sOutValid, 0);
        checkOutput("post-reset in_ready", sInReady, 0);
        loadPacket(0, 1, 16'h0F02);
        loadPacket(5, 1, 16'h0F02);
        expectPacket(0, 1, 16'h0F02);
        expectPacket(5, 1, 16'h0F02);
        drain("re-arbitration", 30);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule
